// File: rtl/route_stack_ctrl.sv
// Path-stack sequencer: records explored turns, replays them reversed on dead ends,
// and unwinds the whole stack on goal to return the car to its start point.
module route_stack_ctrl #(
    parameter int unsigned DEPTH   = 49,
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned TIMEOUT = 50000,
    parameter int unsigned TO_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             turn_valid,
    input  logic [1:0]       turn_code,
    input  logic             dead_end,
    input  logic             goal_reached,
    input  logic             move_done,
    output logic             stk_en,
    output logic             stk_push,
    output logic [1:0]       stk_push_val,
    output logic             stk_pop,
    input  logic [1:0]       stk_pop_val,
    output logic             cmd_valid,
    output logic [1:0]       cmd_dir,
    output logic [CNT_W-1:0] depth,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_EXPLORE,
        S_PUSH_GAP,
        S_POP,
        S_POP_GAP,
        S_CAPTURE,
        S_WAIT_MOVE,
        S_DONE,
        S_ERR
    } state_t;

    typedef enum logic {
        M_BACKTRACK,
        M_RETURN
    } mode_t;

    localparam logic [CNT_W-1:0] DEPTH_MAX = CNT_W'(DEPTH);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d;
    logic [CNT_W-1:0] depth_q, depth_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             stk_en_q, stk_en_d;
    logic             stk_push_q, stk_push_d;
    logic [1:0]       stk_push_val_q, stk_push_val_d;
    logic             stk_pop_q, stk_pop_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [1:0]       cmd_dir_q, cmd_dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;
    logic             err_q, err_d;

    // Undoing a turn swaps left and right; straight and u-turn are self-inverse.
    function automatic logic [1:0] rev_turn(input logic [1:0] code);
        return {code[0], code[1]};
    endfunction

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        depth_d        = depth_q;
        to_cnt_d       = to_cnt_q;
        stk_push_d     = 1'b0;
        stk_push_val_d = stk_push_val_q;
        stk_pop_d      = 1'b0;
        cmd_valid_d    = 1'b0;
        cmd_dir_d      = cmd_dir_q;
        overflow_d     = overflow_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_EXPLORE;
                    depth_d    = '0;
                    to_cnt_d   = '0;
                    overflow_d = 1'b0;
                end
            end
            S_EXPLORE: begin
                if (goal_reached) begin
                    if (depth_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        mode_d  = M_RETURN;
                        state_d = S_POP;
                    end
                end else if (dead_end) begin
                    if (depth_q != '0) begin
                        mode_d  = M_BACKTRACK;
                        state_d = S_POP;
                    end
                end else if (turn_valid) begin
                    if (depth_q < DEPTH_MAX) begin
                        stk_push_d     = 1'b1;
                        stk_push_val_d = turn_code;
                        state_d        = S_PUSH_GAP;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            S_PUSH_GAP: begin
                if (depth_q < DEPTH_MAX) begin
                    depth_d = depth_q + CNT_W'(1);
                end
                state_d = S_EXPLORE;
            end
            S_POP: begin
                stk_pop_d = 1'b1;
                state_d   = S_POP_GAP;
            end
            S_POP_GAP: begin
                state_d = S_CAPTURE;
            end
            // The stack presents the popped entry one cycle after it samples the pop.
            S_CAPTURE: begin
                cmd_dir_d   = rev_turn(stk_pop_val);
                cmd_valid_d = 1'b1;
                if (depth_q != '0) begin
                    depth_d = depth_q - CNT_W'(1);
                end
                to_cnt_d = '0;
                state_d  = S_WAIT_MOVE;
            end
            S_WAIT_MOVE: begin
                if (move_done) begin
                    if (mode_q == M_BACKTRACK) begin
                        state_d = S_EXPLORE;
                    end else if (depth_q != '0) begin
                        state_d = S_POP;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags follow the state being entered so they stay registered.
        busy_d   = !(state_d inside {S_IDLE, S_DONE, S_ERR});
        done_d   = (state_d == S_DONE);
        err_d    = (state_d == S_ERR);
        stk_en_d = !(state_d inside {S_IDLE, S_ERR});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            mode_q         <= M_BACKTRACK;
            depth_q        <= '0;
            to_cnt_q       <= '0;
            stk_en_q       <= 1'b0;
            stk_push_q     <= 1'b0;
            stk_push_val_q <= '0;
            stk_pop_q      <= 1'b0;
            cmd_valid_q    <= 1'b0;
            cmd_dir_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            overflow_q     <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            depth_q        <= depth_d;
            to_cnt_q       <= to_cnt_d;
            stk_en_q       <= stk_en_d;
            stk_push_q     <= stk_push_d;
            stk_push_val_q <= stk_push_val_d;
            stk_pop_q      <= stk_pop_d;
            cmd_valid_q    <= cmd_valid_d;
            cmd_dir_q      <= cmd_dir_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            overflow_q     <= overflow_d;
            err_q          <= err_d;
        end
    end

    assign stk_en       = stk_en_q;
    assign stk_push     = stk_push_q;
    assign stk_push_val = stk_push_val_q;
    assign stk_pop      = stk_pop_q;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_dir      = cmd_dir_q;
    assign depth        = depth_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overflow     = overflow_q;
    assign err          = err_q;

endmodule

// File: tb/tb_route_stack_ctrl.sv
// Directed bench for route_stack_ctrl with a behavioural 2-bit path stack attached.
module tb_route_stack_ctrl;

    localparam int unsigned DEPTH   = 49;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned TO_W    = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, turn_valid, dead_end, goal_reached, move_done;
    logic [1:0]       turn_code;
    logic             stk_en, stk_push, stk_pop, cmd_valid;
    logic [1:0]       stk_push_val, stk_pop_val, cmd_dir;
    logic [CNT_W-1:0] depth;
    logic             busy, done, overflow, err;

    route_stack_ctrl #(
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .turn_valid   (turn_valid),
        .turn_code    (turn_code),
        .dead_end     (dead_end),
        .goal_reached (goal_reached),
        .move_done    (move_done),
        .stk_en       (stk_en),
        .stk_push     (stk_push),
        .stk_push_val (stk_push_val),
        .stk_pop      (stk_pop),
        .stk_pop_val  (stk_pop_val),
        .cmd_valid    (cmd_valid),
        .cmd_dir      (cmd_dir),
        .depth        (depth),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .err          (err)
    );

    always #5 clk = ~clk;

    logic [17:0] outs;
    logic [4:0]  status;
    assign outs   = {stk_en, stk_push, stk_push_val, stk_pop, cmd_valid, cmd_dir,
                     depth, busy, done, overflow, err};
    assign status = {stk_en, busy, done, err, overflow};

    // Path stack: acts on push/pop seen high at a clock edge; popped value appears next cycle.
    logic [1:0] stk_mem [0:63];
    int         stk_sp;
    logic       stk_clr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stk_sp      <= 0;
            stk_pop_val <= 2'b00;
        end else if (stk_clr) begin
            stk_sp <= 0;
        end else begin
            if (stk_push && stk_sp < 64) begin
                stk_mem[stk_sp] <= stk_push_val;
                stk_sp          <= stk_sp + 1;
            end
            if (stk_pop && stk_sp > 0) begin
                stk_pop_val <= stk_mem[stk_sp-1];
                stk_sp      <= stk_sp - 1;
            end
        end
    end

    // Pulse monitor, sampled shortly after each rising edge.
    logic [1:0] push_log [0:255];
    logic [1:0] cmd_log  [0:255];
    int push_cnt = 0, pop_cnt = 0, cmd_cnt = 0;
    int push_wide = 0, pop_wide = 0;
    logic push_prev = 1'b0, pop_prev = 1'b0;

    always @(posedge clk) begin
        #2;
        if (stk_push) begin
            push_log[push_cnt[7:0]] = stk_push_val;
            push_cnt++;
            if (push_prev) push_wide++;
        end
        if (stk_pop) begin
            pop_cnt++;
            if (pop_prev) pop_wide++;
        end
        if (cmd_valid) begin
            cmd_log[cmd_cnt[7:0]] = cmd_dir;
            cmd_cnt++;
        end
        push_prev = stk_push;
        pop_prev  = stk_pop;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic s, input logic tv, input logic de, input logic gr,
                          input logic md, input logic [1:0] code);
        @(negedge clk);
        start        = s;
        turn_valid   = tv;
        dead_end     = de;
        goal_reached = gr;
        move_done    = md;
        turn_code    = code;
        @(negedge clk);
        start        = 1'b0;
        turn_valid   = 1'b0;
        dead_end     = 1'b0;
        goal_reached = 1'b0;
        move_done    = 1'b0;
    endtask

    // Returns at the first falling edge where cmd_valid is high.
    task automatic wait_cmd();
        int  c0;
        bit  seen;
        c0   = cmd_cnt;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (cmd_cnt > c0) seen = 1'b1;
        end
        if (!seen) chk("cmd_wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [1:0] fill_code(input int i);
        return 2'((i + 1) % 4);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int pb, pc, mism;
        rst          = 1'b1;
        start        = 1'b0;
        turn_valid   = 1'b0;
        dead_end     = 1'b0;
        goal_reached = 1'b0;
        move_done    = 1'b0;
        turn_code    = 2'b00;
        stk_clr      = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(outs), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_without_start", 32'(outs), 32'd0);

        // Explore three turns, then return home.
        strobe(1, 0, 0, 0, 0, 2'b00);
        chk("explore_status", 32'(status), 32'b11000);
        strobe(0, 1, 0, 0, 0, 2'b01);
        @(negedge clk);
        strobe(0, 1, 0, 0, 0, 2'b00);
        @(negedge clk);
        strobe(0, 1, 0, 0, 0, 2'b10);
        repeat (2) @(negedge clk);
        chk("push_count_3", 32'(push_cnt), 32'd3);
        chk("push_vals_3", 32'({push_log[0], push_log[1], push_log[2]}), 32'b01_00_10);
        chk("depth_3", 32'(depth), 32'd3);

        strobe(0, 0, 0, 1, 0, 2'b00);
        for (int k = 0; k < 3; k++) begin
            wait_cmd();
            chk("return_depth", 32'(depth), 32'(2 - k));
            repeat (4) @(negedge clk);
            strobe(0, 0, 0, 0, 1, 2'b00);
        end
        chk("return_cmd_seq", 32'({cmd_log[0], cmd_log[1], cmd_log[2]}), 32'b01_00_10);
        chk("return_done_status", 32'(status), 32'b10100);
        chk("return_depth_0", 32'(depth), 32'd0);
        chk("return_pop_count", 32'(pop_cnt), 32'd3);

        // Backtrack a single entry, then keep exploring.
        strobe(1, 0, 0, 0, 0, 2'b00);
        chk("restart_depth", 32'(depth), 32'd0);
        strobe(0, 1, 0, 0, 0, 2'b11);
        @(negedge clk);
        strobe(0, 1, 0, 0, 0, 2'b01);
        @(negedge clk);
        strobe(0, 0, 1, 0, 0, 2'b00);
        wait_cmd();
        chk("backtrack_cmd_dir", 32'(cmd_dir), 32'b10);
        chk("backtrack_depth", 32'(depth), 32'd1);
        repeat (4) @(negedge clk);
        strobe(0, 0, 0, 0, 1, 2'b00);
        repeat (2) @(negedge clk);
        chk("backtrack_status", 32'(status), 32'b11000);
        chk("backtrack_cmd_count", 32'(cmd_cnt), 32'd4);
        strobe(0, 1, 0, 0, 0, 2'b00);
        repeat (2) @(negedge clk);
        chk("post_backtrack_depth", 32'(depth), 32'd2);
        chk("post_backtrack_push", 32'(push_cnt), 32'd6);
        chk("post_backtrack_val", 32'(push_log[5]), 32'b00);

        // Fill to DEPTH, overflow, then time out on the return leg.
        do_reset();
        strobe(1, 0, 0, 0, 0, 2'b00);
        pb = push_cnt;
        for (int i = 0; i < 49; i++) begin
            strobe(0, 1, 0, 0, 0, fill_code(i));
            @(negedge clk);
        end
        chk("full_push_count", 32'(push_cnt - pb), 32'd49);
        chk("full_depth", 32'(depth), 32'd49);
        chk("full_no_overflow", 32'(overflow), 32'd0);
        strobe(0, 1, 0, 0, 0, 2'b11);
        repeat (2) @(negedge clk);
        chk("overflow_no_push", 32'(push_cnt - pb), 32'd49);
        chk("overflow_flag", 32'(overflow), 32'd1);
        chk("overflow_depth", 32'(depth), 32'd49);
        mism = 0;
        for (int i = 0; i < 49; i++) begin
            if (push_log[pb + i] !== fill_code(i)) mism++;
        end
        chk("full_push_vals", 32'(mism), 32'd0);

        strobe(0, 0, 0, 1, 0, 2'b00);
        wait_cmd();
        chk("timeout_cmd_dir", 32'(cmd_dir), 32'b10);
        chk("timeout_depth", 32'(depth), 32'd48);
        repeat (7) @(negedge clk);
        chk("err_not_early", 32'(err), 32'd0);
        @(negedge clk);
        chk("err_at_timeout", 32'(err), 32'd1);
        chk("err_status", 32'(status), 32'b00011);
        stk_clr = 1'b1;
        strobe(1, 0, 0, 0, 0, 2'b00);
        stk_clr = 1'b0;
        chk("err_recover_status", 32'(status), 32'b11000);
        chk("err_recover_depth", 32'(depth), 32'd0);

        // Reset while the pop pulse is out.
        strobe(0, 1, 0, 0, 0, 2'b10);
        @(negedge clk);
        strobe(0, 0, 0, 1, 0, 2'b00);
        @(negedge clk);
        chk("in_pop_gap", 32'(stk_pop), 32'd1);
        pc  = pop_cnt;
        rst = 1'b1;
        #1;
        chk("midop_reset_outputs", 32'(outs), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midop_no_pop", 32'(pop_cnt), 32'(pc));
        chk("midop_idle_status", 32'(status), 32'd0);

        // Empty-stack goal/dead end, with a same-cycle turn that must be dropped.
        strobe(1, 0, 0, 0, 0, 2'b00);
        pb = push_cnt;
        strobe(0, 1, 0, 1, 0, 2'b01);
        chk("empty_goal_done", 32'(status), 32'b10100);
        chk("empty_goal_no_push", 32'(push_cnt), 32'(pb));
        strobe(1, 0, 0, 0, 0, 2'b00);
        strobe(0, 1, 1, 0, 0, 2'b11);
        repeat (3) @(negedge clk);
        chk("empty_dead_status", 32'(status), 32'b11000);
        chk("empty_dead_depth", 32'(depth), 32'd0);
        chk("empty_dead_no_push", 32'(push_cnt), 32'(pb));
        chk("empty_dead_no_pop", 32'(pop_cnt), 32'(pc));

        chk("push_width", 32'(push_wide), 32'd0);
        chk("pop_width", 32'(pop_wide), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
